// File: rtl/int_request_ctrl_if.sv
// Bus between the interrupt request controller and its environment:
// raw IRQ lines, mask write port, handler return, and request/status outputs.
interface int_request_ctrl_if #(
   parameter int N_SRC   = 8,
   parameter int CAUSE_W = 3
);
   logic [N_SRC-1:0]   irq_in;
   logic               mask_we;
   logic [N_SRC-1:0]   mask_wdata;
   logic               eret;
   logic               int_req;
   logic [CAUSE_W-1:0] int_cause;
   logic               int_active;
   logic [N_SRC-1:0]   pending;
   logic [N_SRC-1:0]   mask;

   // Environment side: drives the lines and mask writes, observes requests.
   modport master (
      output irq_in, mask_we, mask_wdata, eret,
      input  int_req, int_cause, int_active, pending, mask
   );

   // Controller side.
   modport slave (
      input  irq_in, mask_we, mask_wdata, eret,
      output int_req, int_cause, int_active, pending, mask
   );
endinterface

// File: rtl/int_request_ctrl.sv
// Interrupt request controller feeding the PC/EPC interrupt unit.
// Synchronises IRQ lines, latches rising edges as pending requests, masks them,
// picks the lowest-index eligible source and issues a one-cycle int_req.
// No nesting: further requests wait in pending until the handler's eret.
module int_request_ctrl #(
   parameter int               N_SRC    = 8,
   parameter int               CAUSE_W  = 3,
   parameter logic [N_SRC-1:0] MASK_RST = 8'hFF
) (
   input logic               clk,
   input logic               reset,
   int_request_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      TAKE    = 2'd1,
      SERVICE = 2'd2
   } state_t;

   state_t             state;
   state_t             state_next;
   logic [N_SRC-1:0]   s1;
   logic [N_SRC-1:0]   s2;
   logic [N_SRC-1:0]   s2_d;
   logic [N_SRC-1:0]   rise;
   logic [N_SRC-1:0]   eligible;
   logic [N_SRC-1:0]   clr;
   logic [N_SRC-1:0]   pending;
   logic [N_SRC-1:0]   pending_next;
   logic [N_SRC-1:0]   mask;
   logic [CAUSE_W-1:0] sel;
   logic [CAUSE_W-1:0] int_cause;
   logic               take;

   // Priority encoder: index of the lowest set bit (0 when none set).
   function automatic logic [CAUSE_W-1:0] lowest_set(input logic [N_SRC-1:0] v);
      logic [CAUSE_W-1:0] idx;
      idx = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (v[i]) idx = CAUSE_W'(i);
      end
      return idx;
   endfunction

   // Two-flop synchroniser plus one delay stage for edge detection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1   <= '0;
         s2   <= '0;
         s2_d <= '0;
      end else begin
         s1   <= bus.irq_in;
         s2   <= s1;
         s2_d <= s2;
      end
   end

   // Edge detect, eligibility, selection and pending update; a new edge on the
   // source being taken wins over its clear so that request is not lost.
   always_comb begin
      rise         = s2 & ~s2_d;
      eligible     = pending & mask;
      sel          = lowest_set(eligible);
      take         = (state == IDLE) && (eligible != '0);
      clr          = '0;
      if (take) clr = N_SRC'(1) << sel;
      pending_next = (pending & ~clr) | rise;
   end

   // Pending requests, mask register and the cause of the last taken source.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending   <= '0;
         mask      <= MASK_RST;
         int_cause <= '0;
      end else begin
         pending <= pending_next;
         if (bus.mask_we) mask <= bus.mask_wdata;
         if (take) int_cause <= sel;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // FSM next state: TAKE lasts one cycle; eret only counts in SERVICE.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (take) state_next = TAKE;
         TAKE:    state_next = SERVICE;
         SERVICE: if (bus.eret) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign bus.int_req    = (state == TAKE);
   assign bus.int_active = (state == TAKE) || (state == SERVICE);
   assign bus.int_cause  = int_cause;
   assign bus.pending    = pending;
   assign bus.mask       = mask;

endmodule

// File: tb/tb_int_request_ctrl.sv
// Directed bench for int_request_ctrl: reset, single source, priority, mask,
// blocking during service, and set/clear collision on the taken source.
module tb_int_request_ctrl;
   logic clk;
   logic reset;
   int   errors;
   int   checks;

   int_request_ctrl_if #(.N_SRC(8), .CAUSE_W(3)) bus ();

   int_request_ctrl #(.N_SRC(8), .CAUSE_W(3), .MASK_RST(8'hFF)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle 1 time unit past it.
   task automatic tick(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Return from service (must be in SERVICE), then let lines go quiet.
   task automatic finish_service();
      bus.eret = 1'b1;
      tick();
      bus.eret   = 1'b0;
      bus.irq_in = 8'h00;
      tick(3);
   endtask

   task automatic test_reset();
      bus.mask_we = 1'b1; bus.mask_wdata = 8'hF0;
      tick();
      bus.mask_we = 1'b0;
      bus.irq_in  = 8'h01;
      tick(4);
      checks++; if (bus.pending !== 8'h01) begin errors++; $display("FAIL t1_pre_pending got=%h exp=01", bus.pending); end
      checks++; if (bus.mask !== 8'hF0) begin errors++; $display("FAIL t1_pre_mask got=%h exp=f0", bus.mask); end
      #3 reset = 1'b1;
      #1;
      checks++; if (bus.pending !== 8'h00) begin errors++; $display("FAIL t1_async_pending got=%h exp=00", bus.pending); end
      checks++; if (bus.mask !== 8'hFF) begin errors++; $display("FAIL t1_async_mask got=%h exp=ff", bus.mask); end
      checks++; if ({bus.int_req, bus.int_active, bus.int_cause} !== 5'b0) begin errors++; $display("FAIL t1_async_outs got=%b exp=00000", {bus.int_req, bus.int_active, bus.int_cause}); end
      tick();
      reset = 1'b0;
      for (int e = 1; e <= 3; e++) begin
         tick();
         checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL t1_early_req edge=%0d got=%b exp=0", e, bus.int_req); end
      end
      checks++; if (bus.pending !== 8'h01) begin errors++; $display("FAIL t1_pending_e3 got=%h exp=01", bus.pending); end
      tick();
      checks++; if (bus.int_req !== 1'b1 || bus.int_cause !== 3'd0) begin errors++; $display("FAIL t1_take_e4 got req=%b cause=%0d exp req=1 cause=0", bus.int_req, bus.int_cause); end
      tick();
      checks++; if (bus.int_req !== 1'b0 || bus.int_active !== 1'b1) begin errors++; $display("FAIL t1_service got req=%b act=%b exp req=0 act=1", bus.int_req, bus.int_active); end
      finish_service();
      checks++; if (bus.int_active !== 1'b0 || bus.int_cause !== 3'd0) begin errors++; $display("FAIL t1_idle got act=%b cause=%0d exp act=0 cause=0", bus.int_active, bus.int_cause); end
   endtask

   task automatic test_single();
      int extra;
      bus.irq_in = 8'h08;
      tick(3);
      checks++; if (bus.pending !== 8'h08 || bus.int_req !== 1'b0) begin errors++; $display("FAIL t2_pending got pend=%h req=%b exp pend=08 req=0", bus.pending, bus.int_req); end
      tick();
      checks++; if (bus.int_req !== 1'b1 || bus.int_cause !== 3'd3 || bus.pending !== 8'h00 || bus.int_active !== 1'b1) begin
         errors++; $display("FAIL t2_take got req=%b cause=%0d pend=%h act=%b exp 1/3/00/1", bus.int_req, bus.int_cause, bus.pending, bus.int_active);
      end
      extra = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (bus.int_req !== 1'b0) extra++;
      end
      checks++; if (extra != 0) begin errors++; $display("FAIL t2_held_service got pulses=%0d exp=0", extra); end
      bus.eret = 1'b1;
      tick();
      bus.eret = 1'b0;
      tick(3);
      checks++; if (bus.int_req !== 1'b0 || bus.pending !== 8'h00 || bus.int_cause !== 3'd3) begin
         errors++; $display("FAIL t2_no_retrigger got req=%b pend=%h cause=%0d exp 0/00/3", bus.int_req, bus.pending, bus.int_cause);
      end
      bus.irq_in = 8'h00;
      tick(3);
   endtask

   task automatic test_priority();
      bus.irq_in = 8'h24;
      tick(4);
      checks++; if (bus.int_req !== 1'b1 || bus.int_cause !== 3'd2 || bus.pending !== 8'h20) begin
         errors++; $display("FAIL t3_first got req=%b cause=%0d pend=%h exp 1/2/20", bus.int_req, bus.int_cause, bus.pending);
      end
      tick();
      bus.eret = 1'b1;
      tick();
      bus.eret = 1'b0;
      checks++; if (bus.int_req !== 1'b0 || bus.int_active !== 1'b0) begin errors++; $display("FAIL t3_idle got req=%b act=%b exp 0/0", bus.int_req, bus.int_active); end
      tick();
      checks++; if (bus.int_req !== 1'b1 || bus.int_cause !== 3'd5 || bus.pending !== 8'h00) begin
         errors++; $display("FAIL t3_second got req=%b cause=%0d pend=%h exp 1/5/00", bus.int_req, bus.int_cause, bus.pending);
      end
      tick();
      finish_service();
   endtask

   task automatic test_mask();
      int pulses;
      bus.mask_we = 1'b1; bus.mask_wdata = 8'hFE;
      tick();
      bus.mask_we = 1'b0;
      checks++; if (bus.mask !== 8'hFE) begin errors++; $display("FAIL t4_mask_wr got=%h exp=fe", bus.mask); end
      bus.irq_in = 8'h01;
      pulses = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (bus.int_req !== 1'b0) pulses++;
      end
      checks++; if (pulses != 0 || bus.pending !== 8'h01) begin errors++; $display("FAIL t4_masked got pulses=%0d pend=%h exp 0/01", pulses, bus.pending); end
      bus.mask_we = 1'b1; bus.mask_wdata = 8'hFF;
      tick();
      bus.mask_we = 1'b0;
      checks++; if (bus.int_req !== 1'b0 || bus.mask !== 8'hFF) begin errors++; $display("FAIL t4_unmask_edge got req=%b mask=%h exp 0/ff", bus.int_req, bus.mask); end
      tick();
      checks++; if (bus.int_req !== 1'b1 || bus.int_cause !== 3'd0 || bus.pending !== 8'h00) begin
         errors++; $display("FAIL t4_take got req=%b cause=%0d pend=%h exp 1/0/00", bus.int_req, bus.int_cause, bus.pending);
      end
      tick();
      finish_service();
   endtask

   task automatic test_blocking();
      int pulses;
      bus.irq_in = 8'h02;
      tick(4);
      checks++; if (bus.int_req !== 1'b1 || bus.int_cause !== 3'd1) begin errors++; $display("FAIL t5_first got req=%b cause=%0d exp 1/1", bus.int_req, bus.int_cause); end
      bus.eret   = 1'b1;
      bus.irq_in = 8'h00;
      tick();
      bus.eret = 1'b0;
      checks++; if (bus.int_active !== 1'b1 || bus.int_req !== 1'b0) begin errors++; $display("FAIL t5_eret_in_take got act=%b req=%b exp 1/0", bus.int_active, bus.int_req); end
      tick(3);
      bus.irq_in = 8'h02;
      pulses = 0;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (bus.int_req !== 1'b0) pulses++;
      end
      checks++; if (pulses != 0 || bus.pending !== 8'h02 || bus.int_active !== 1'b1) begin
         errors++; $display("FAIL t5_blocked got pulses=%0d pend=%h act=%b exp 0/02/1", pulses, bus.pending, bus.int_active);
      end
      bus.eret = 1'b1;
      tick();
      bus.eret = 1'b0;
      checks++; if (bus.int_req !== 1'b0 || bus.pending !== 8'h02) begin errors++; $display("FAIL t5_after_eret got req=%b pend=%h exp 0/02", bus.int_req, bus.pending); end
      tick();
      checks++; if (bus.int_req !== 1'b1 || bus.int_cause !== 3'd1 || bus.pending !== 8'h00) begin
         errors++; $display("FAIL t5_retake got req=%b cause=%0d pend=%h exp 1/1/00", bus.int_req, bus.int_cause, bus.pending);
      end
      tick();
      finish_service();
   endtask

   task automatic test_collision();
      bus.irq_in = 8'h40;
      tick(5);
      checks++; if (bus.int_active !== 1'b1 || bus.int_cause !== 3'd6) begin errors++; $display("FAIL t6_busy got act=%b cause=%0d exp 1/6", bus.int_active, bus.int_cause); end
      bus.irq_in = 8'h50;
      tick(3);
      checks++; if (bus.pending !== 8'h10) begin errors++; $display("FAIL t6_pending got=%h exp=10", bus.pending); end
      bus.irq_in = 8'h40;
      tick(3);
      bus.irq_in = 8'h50;
      tick();
      bus.eret = 1'b1;
      tick();
      bus.eret = 1'b0;
      tick();
      checks++; if (bus.int_req !== 1'b1 || bus.int_cause !== 3'd4 || bus.pending !== 8'h10) begin
         errors++; $display("FAIL t6_collide got req=%b cause=%0d pend=%h exp 1/4/10", bus.int_req, bus.int_cause, bus.pending);
      end
      tick();
      bus.eret = 1'b1;
      tick();
      bus.eret = 1'b0;
      tick();
      checks++; if (bus.int_req !== 1'b1 || bus.int_cause !== 3'd4 || bus.pending !== 8'h00) begin
         errors++; $display("FAIL t6_again got req=%b cause=%0d pend=%h exp 1/4/00", bus.int_req, bus.int_cause, bus.pending);
      end
      tick();
      finish_service();
   endtask

   initial begin
      errors         = 0;
      checks         = 0;
      reset          = 1'b1;
      bus.irq_in     = 8'h00;
      bus.mask_we    = 1'b0;
      bus.mask_wdata = 8'h00;
      bus.eret       = 1'b0;
      tick(2);
      reset = 1'b0;
      tick();
      test_reset();
      test_single();
      test_priority();
      test_mask();
      test_blocking();
      test_collision();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
